// File: rtl/decim4x.sv
// Second-order CIC decimator (R=4, M=1) with a 22-bit internal path and an 18-bit output.
// The integrators run at the input rate (clken4x). The comb and output stage run once per four input samples.
module decim4x #(
   parameter int ROUND = 1
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               clken4x,
   input  logic               sync,
   input  logic signed [17:0] xkin,
   output logic signed [17:0] ykout,
   output logic               ykvalid
);

   localparam int W = 22;

   logic [1:0]          phase_q, phase_d;
   logic signed [W-1:0] i1_q, i1_d;
   logic signed [W-1:0] i2_q, i2_d;
   logic signed [W-1:0] i2d_q, i2d_d;
   logic signed [W-1:0] c1_q, c1_d;
   logic signed [W-1:0] c1d_q, c1d_d;
   logic signed [W-1:0] c2_q, c2_d;
   logic signed [17:0]  ykout_q, ykout_d;
   logic                ykvalid_q, ykvalid_d;
   logic                dec;
   logic signed [W-1:0] c2_rnd;

   always_comb begin
      // NOTE: every output gets its hold value first, so no path through this block can infer a latch.
      phase_d   = phase_q;
      i1_d      = i1_q;
      i2_d      = i2_q;
      i2d_d     = i2d_q;
      c1_d      = c1_q;
      c1d_d     = c1d_q;
      c2_d      = c2_q;
      ykout_d   = ykout_q;
      dec       = clken4x && (phase_q == 2'd3) && !sync;
      ykvalid_d = dec;
      c2_rnd    = (ROUND != 0) ? c2_q + 22'sd8 : c2_q;

      // Integrator wrap-around is harmless: the modular comb differences cancel it.
      if (clken4x) begin
         i1_d    = i1_q + {{(W-18){xkin[17]}}, xkin};
         i2_d    = i2_q + i1_q;
         phase_d = sync ? 2'd0 : phase_q + 2'd1;
      end

      if (dec) begin
         c1_d    = i2_q - i2d_q;
         i2d_d   = i2_q;
         c2_d    = c1_q - c1d_q;
         c1d_d   = c1_q;
         ykout_d = 18'(c2_rnd >>> 4);
      end
   end

   // NOTE: registers update with non-blocking assignments, so every _q reads its pre-edge value.
   always_ff @(posedge clock) begin
      if (reset) begin
         phase_q   <= '0;
         i1_q      <= '0;
         i2_q      <= '0;
         i2d_q     <= '0;
         c1_q      <= '0;
         c1d_q     <= '0;
         c2_q      <= '0;
         ykout_q   <= '0;
         ykvalid_q <= 1'b0;
      end else begin
         phase_q   <= phase_d;
         i1_q      <= i1_d;
         i2_q      <= i2_d;
         i2d_q     <= i2d_d;
         c1_q      <= c1_d;
         c1d_q     <= c1d_d;
         c2_q      <= c2_d;
         ykout_q   <= ykout_d;
         ykvalid_q <= ykvalid_d;
      end
   end

   assign ykout   = ykout_q;
   assign ykvalid = ykvalid_q;

endmodule

// File: tb/tb_decim4x.sv
// Directed test bench for decim4x. It runs the rounding and truncating variants side by side.
// Expected outputs come from an FIR model with taps 1,2,3,4,3,2,1, which is applied over the input-sample history.
module tb_decim4x;

   logic               clock = 1'b0;
   logic               reset;
   logic               clken4x;
   logic               sync;
   logic signed [17:0] xkin;
   logic signed [17:0] ykout_r, ykout_t;
   logic               ykvalid_r, ykvalid_t;

   always #5 clock = ~clock;

   decim4x #(.ROUND(1)) dut_r (
      .clock(clock), .reset(reset), .clken4x(clken4x), .sync(sync),
      .xkin(xkin), .ykout(ykout_r), .ykvalid(ykvalid_r)
   );

   decim4x #(.ROUND(0)) dut_t (
      .clock(clock), .reset(reset), .clken4x(clken4x), .sync(sync),
      .xkin(xkin), .ykout(ykout_t), .ykvalid(ykvalid_t)
   );

   int total = 0;
   int bad   = 0;
   int x_hist[$];
   int dec_r[$];
   int dec_t[$];
   int phase_m;
   bit model_en;
   int last_r, last_t;
   int taps[7] = '{1, 2, 3, 4, 3, 2, 1};

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // The output at decimation sample k sees inputs k-10 .. k-16. Nine samples of delay come from the comb pipeline.
   function automatic int model_c2(input int k);
      int acc = 0;
      for (int t = 0; t < 7; t++) begin
         int idx = k - 10 - t;
         if (idx >= 0) acc += taps[t] * x_hist[idx];
      end
      return acc;
   endfunction

   task automatic do_reset();
      reset = 1'b1; clken4x = 1'b1; sync = 1'b1; xkin = 18'sd12345;
      @(posedge clock); #1;
      reset = 1'b0; clken4x = 1'b0; sync = 1'b0; xkin = '0;
      chk("rst_ykout_r", ykout_r, 0);
      chk("rst_ykout_t", ykout_t, 0);
      chk("rst_ykvalid", ykvalid_r, 0);
      x_hist.delete(); dec_r.delete(); dec_t.delete();
      phase_m = 0; model_en = 1'b1; last_r = 0; last_t = 0;
   endtask

   task automatic step(input int x, input bit s, input int idle);
      bit exp_dec;
      int k, c2;
      k = x_hist.size();
      x_hist.push_back(x);
      exp_dec = !s && (phase_m == 3);
      phase_m = s ? 0 : (phase_m + 1) % 4;
      if (s) model_en = 1'b0;
      clken4x = 1'b1; sync = s; xkin = 18'(x);
      @(posedge clock); #1;
      clken4x = 1'b0; sync = 1'b0;
      chk("ykvalid_r", ykvalid_r, exp_dec);
      chk("ykvalid_t", ykvalid_t, exp_dec);
      if (exp_dec) begin
         dec_r.push_back(int'(ykout_r));
         dec_t.push_back(int'(ykout_t));
         if (model_en) begin
            c2 = model_c2(k);
            last_r = (c2 + 8) >>> 4;
            last_t = c2 >>> 4;
            chk("ykout_r_model", ykout_r, last_r);
            chk("ykout_t_model", ykout_t, last_t);
         end
      end
      repeat (idle) begin
         @(posedge clock); #1;
         chk("idle_ykvalid", ykvalid_r, 0);
         if (model_en) chk("idle_hold", ykout_r, last_r);
      end
   endtask

   initial begin
      int sum;
      reset = 1'b1; clken4x = 1'b0; sync = 1'b0; xkin = '0;
      repeat (2) @(posedge clock);
      #1;
      chk("por_ykout", ykout_r, 0);
      chk("por_ykvalid", ykvalid_r, 0);

      // DC: 1000 on every fourth clock
      do_reset();
      for (int i = 0; i < 40; i++) step(1000, 1'b0, 3);
      chk("dc_count", dec_r.size(), 10);
      chk("dc_y3_round", dec_r[2], 188);
      chk("dc_y3_trunc", dec_t[2], 187);
      chk("dc_y4_round", dec_r[3], 938);
      chk("dc_y4_trunc", dec_t[3], 937);
      for (int i = 4; i < 10; i++) chk("dc_settled", dec_r[i], 1000);

      // Impulse, back-to-back enables. A decimated impulse picks one phase of the taps, and that phase always sums to 4.
      do_reset();
      step(1600, 1'b0, 0);
      for (int i = 0; i < 23; i++) step(0, 1'b0, 0);
      sum = 0;
      foreach (dec_r[i]) begin
         sum += dec_r[i];
         if (dec_r[i] != 0)
            chk("imp_mult100", (dec_r[i] % 100 == 0) && dec_r[i] >= 100 && dec_r[i] <= 400, 1);
      end
      chk("imp_sum", sum, 400);
      chk("imp_y3", dec_r[2], 200);
      chk("imp_y4", dec_r[3], 200);

      // Impulse on a different input phase lands on the centre tap
      do_reset();
      step(0, 1'b0, 0); step(0, 1'b0, 0);
      step(1600, 1'b0, 0);
      for (int i = 0; i < 21; i++) step(0, 1'b0, 0);
      sum = 0;
      foreach (dec_r[i]) sum += dec_r[i];
      chk("imp2_sum", sum, 400);
      chk("imp2_y4", dec_r[3], 400);

      // Full scale in both directions
      do_reset();
      for (int i = 0; i < 40; i++) step(-131072, 1'b0, 0);
      chk("fs_neg_r", dec_r[$], -131072);
      chk("fs_neg_t", dec_t[$], -131072);
      for (int i = 0; i < 40; i++) step(131071, 1'b0, 1);
      chk("fs_pos_r", dec_r[$], 131071);
      chk("fs_pos_t", dec_t[$], 131071);

      // Ramp with a reset mid-run. Reset is applied while clken4x and sync are both high.
      do_reset();
      for (int i = 0; i < 30; i++) step(i * 300 - 4000, 1'b0, 0);
      do_reset();
      for (int i = 0; i < 30; i++) step(i * 300 - 4000, 1'b0, 1);

      // A 50-clock enable gap mid-stream must not change the output sequence
      do_reset();
      for (int i = 0; i < 40; i++)
         step(((i * 7919) % 2001) * 60 - 60000, 1'b0, (i == 19) ? 50 : 1);
      chk("gap_count", dec_r.size(), 10);

      // Sync at phase 1, then sync at phase 3 (which suppresses a decimation)
      do_reset();
      step(500, 1'b0, 1);
      step(500, 1'b1, 1);
      repeat (3) step(500, 1'b0, 1);
      chk("sync_none_yet", dec_r.size(), 0);
      step(500, 1'b0, 1);
      chk("sync_first", dec_r.size(), 1);
      repeat (4) step(500, 1'b0, 1);
      chk("sync_second", dec_r.size(), 2);
      repeat (3) step(500, 1'b0, 1);
      step(500, 1'b1, 1);
      chk("sync_ph3_suppressed", dec_r.size(), 2);
      repeat (3) step(500, 1'b0, 1);
      chk("sync_ph3_wait", dec_r.size(), 2);
      step(500, 1'b0, 1);
      chk("sync_ph3_next", dec_r.size(), 3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
